// File: rtl/sram_test_if.sv
// Bus bundle for the sram_test macro: one access per clock, registered read data.
interface sram_test_if #(
  parameter int DATA_WIDTH  = 4,
  parameter int ADDR_WIDTH  = 6,
  parameter int WMASK_WIDTH = 2
);
  logic                   we;
  logic [WMASK_WIDTH-1:0] wmask;
  logic [ADDR_WIDTH-1:0]  addr;
  logic [DATA_WIDTH-1:0]  din;
  logic [DATA_WIDTH-1:0]  dout;

  // The requester drives the access; the memory returns read data.
  modport master (output we, wmask, addr, din, input dout);
  modport slave  (input we, wmask, addr, din, output dout);
endinterface

// File: rtl/sram_test.sv
// Single-port, byte-maskable, flop-based SRAM model. Each rising edge performs
// one masked write or one read; read data is registered with one cycle latency.
// DATA_WIDTH must be an integer multiple of WMASK_WIDTH.
module sram_test #(
  parameter int DATA_WIDTH  = 4,
  parameter int ADDR_WIDTH  = 6,
  parameter int WMASK_WIDTH = 2
) (
  input logic       clock,
  input logic       reset,
  sram_test_if.slave bus
);
  localparam int RAM_DEPTH  = 1 << ADDR_WIDTH;
  localparam int LANE_WIDTH = DATA_WIDTH / WMASK_WIDTH;

  logic [DATA_WIDTH-1:0] mem_q [RAM_DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [RAM_DEPTH];
  logic [DATA_WIDTH-1:0] dout_q;
  logic [DATA_WIDTH-1:0] dout_d;

  // Next-state: merge enabled lanes on a write, capture the addressed word on a read.
  always_comb begin
    // NOTE: every signal gets a hold-value default first so no path leaves it unassigned (no latch).
    mem_d  = mem_q;
    dout_d = dout_q;
    if (bus.we) begin
      for (int i = 0; i < WMASK_WIDTH; i++) begin
        if (bus.wmask[i]) begin
          mem_d[bus.addr][i*LANE_WIDTH +: LANE_WIDTH] = bus.din[i*LANE_WIDTH +: LANE_WIDTH];
        end
      end
    end else begin
      dout_d = mem_q[bus.addr];
    end
  end

  // State update; synchronous reset wins over any access in the same cycle.
  always_ff @(posedge clock) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      // NOTE: the array itself is cleared on reset because reset must discard prior writes.
      for (int w = 0; w < RAM_DEPTH; w++) begin
        mem_q[w] <= '0;
      end
      dout_q <= '0;
    end else begin
      for (int w = 0; w < RAM_DEPTH; w++) begin
        mem_q[w] <= mem_d[w];
      end
      dout_q <= dout_d;
    end
  end

  // Read data comes straight from a flop: no combinational input-to-output path.
  assign bus.dout = dout_q;
endmodule

// File: tb/tb_sram_test.sv
// Self-checking bench for sram_test: directed plan followed by random traffic,
// every cycle compared against a word-level reference memory.
module tb_sram_test;
  logic clock = 1'b0;
  logic reset = 1'b0;

  int vectors     = 0;
  int miscompares = 0;

  logic [3:0] ref_mem [64];
  logic [3:0] ref_dout = 4'h0;

  sram_test_if #(.DATA_WIDTH(4), .ADDR_WIDTH(6), .WMASK_WIDTH(2)) bus ();

  sram_test #(.DATA_WIDTH(4), .ADDR_WIDTH(6), .WMASK_WIDTH(2)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One access: drive on the falling edge, let the rising edge sample it,
  // update the reference, then compare dout shortly after the edge.
  task automatic cycle(input logic r, input logic w, input logic [1:0] m,
                       input logic [5:0] a, input logic [3:0] d);
    logic [3:0] bitmask;
    @(negedge clock);
    reset     = r;
    bus.we    = w;
    bus.wmask = m;
    bus.addr  = a;
    bus.din   = d;
    @(posedge clock);
    bitmask = {m[1], m[1], m[0], m[0]};
    if (r) begin
      foreach (ref_mem[k]) ref_mem[k] = 4'h0;
      ref_dout = 4'h0;
    end else if (w) begin
      ref_mem[a] = (ref_mem[a] & ~bitmask) | (d & bitmask);
    end else begin
      ref_dout = ref_mem[a];
    end
    #1;
    check("model", bus.dout, ref_dout);
  endtask

  task automatic rd(input logic [5:0] a);
    cycle(1'b0, 1'b0, 2'b00, a, 4'h0);
  endtask

  task automatic wr(input logic [5:0] a, input logic [3:0] d, input logic [1:0] m);
    cycle(1'b0, 1'b1, m, a, d);
  endtask

  initial begin
    bus.we    = 1'b0;
    bus.wmask = 2'b00;
    bus.addr  = '0;
    bus.din   = '0;
    foreach (ref_mem[k]) ref_mem[k] = 4'h0;

    // Reset and read back zeros at both ends of the address range.
    cycle(1'b1, 1'b0, 2'b00, 6'd0, 4'h0);
    check("rst_dout", bus.dout, 4'h0);
    rd(6'd0);   check("rd0_after_rst", bus.dout, 4'h0);
    rd(6'd63);  check("rd63_after_rst", bus.dout, 4'h0);

    // Full write, dout held during the write, then read back.
    wr(6'd0, 4'd13, 2'b11); check("dout_hold_on_wr", bus.dout, 4'h0);
    rd(6'd0);               check("full_wr", bus.dout, 4'd13);

    // Partial masks on addr 0 (currently 4'b1101).
    wr(6'd0, 4'b0010, 2'b01); rd(6'd0); check("mask01", bus.dout, 4'b1110);
    wr(6'd0, 4'b0000, 2'b10); rd(6'd0); check("mask10", bus.dout, 4'b0010);
    wr(6'd0, 4'b1111, 2'b00); rd(6'd0); check("mask00", bus.dout, 4'b0010);

    // Address independence.
    wr(6'd63, 4'hA, 2'b11);
    wr(6'd1,  4'h5, 2'b11);
    rd(6'd63); check("ind63", bus.dout, 4'hA);
    rd(6'd1);  check("ind1",  bus.dout, 4'h5);
    rd(6'd0);  check("ind0",  bus.dout, 4'b0010);

    // Read-after-write and back-to-back alternating reads.
    wr(6'd5, 4'h3, 2'b11);
    rd(6'd5);  check("raw5",  bus.dout, 4'h3);
    rd(6'd5);  check("alt5a", bus.dout, 4'h3);
    rd(6'd63); check("alt63", bus.dout, 4'hA);
    rd(6'd5);  check("alt5b", bus.dout, 4'h3);

    // Reset mid-sequence with a write pending: reset wins and clears everything.
    cycle(1'b1, 1'b1, 2'b11, 6'd2, 4'hF);
    check("midrst_dout", bus.dout, 4'h0);
    rd(6'd2);  check("midrst2",  bus.dout, 4'h0);
    rd(6'd5);  check("midrst5",  bus.dout, 4'h0);
    rd(6'd63); check("midrst63", bus.dout, 4'h0);

    // Random traffic, addresses biased toward a small set so reads hit written words.
    for (int n = 0; n < 600; n++) begin
      logic       r;
      logic       w;
      logic [1:0] m;
      logic [5:0] a;
      logic [3:0] d;
      r = ($urandom_range(0, 63) == 0);
      w = $urandom_range(0, 1);
      m = 2'($urandom_range(0, 3));
      a = ($urandom_range(0, 1) != 0) ? 6'($urandom_range(0, 7)) : 6'($urandom_range(0, 63));
      d = 4'($urandom_range(0, 15));
      cycle(r, w, m, a, d);
    end

    // Final sweep: read every word back against the reference.
    for (int a = 0; a < 64; a++) begin
      rd(6'(a));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
